// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto one memory port: IDLE/BUSY/DONE FSM, registered read data, one-cycle ack, timeout abort.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed port-0 priority.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              gnt
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              gnt_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              ack0_nxt, ack1_nxt, err_nxt;
  logic              rd_ld;
  logic [DATA_W-1:0] rd_val;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_gnt, last_gnt_nxt;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rd_ld     = 1'b0;
    rd_val    = mem_rdata;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = gnt ? addr1 : addr0;
    mem_wdata = gnt ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_nxt = last_gnt;
`endif
    case (state)
      IDLE: begin
        if (req0 | req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          gnt_nxt = (req0 & req1) ? ~last_gnt : ~req0;
`else
          gnt_nxt = ~req0;
`endif
          cnt_nxt   = 8'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Gate with reset so the memory sees the request drop the instant reset rises.
        mem_req = ~reset;
        mem_we  = ~reset & (gnt ? we1 : we0);
        if (mem_ready) begin
          rd_ld     = 1'b1;
          ack0_nxt  = ~gnt;
          ack1_nxt  = gnt;
          state_nxt = DONE;
        end else if (cnt == TMO_LAST) begin
          rd_ld     = 1'b1;
          rd_val    = '0;
          ack0_nxt  = ~gnt;
          ack1_nxt  = gnt;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      DONE: begin
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt_nxt = gnt;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      cnt   <= 8'd0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
      ack0  <= ack0_nxt;
      ack1  <= ack1_nxt;
      err   <= err_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= last_gnt_nxt;
`endif
    end
  end

  // Read-data capture for the granted port; the other port holds its value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (rd_ld) begin
      if (gnt) rdata1 <= rd_val;
      else     rdata0 <= rd_val;
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory port between two requesters: port 0 = multicycle core (fetch and load/store), port 1 = external loader/DMA.
- Sits between the core datapath/controller and the memory model.
- Serialises accesses with a 3-state FSM, latches read data, and returns a one-cycle ack per transaction.
- Aborts with an error ack on a memory timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, BUSY cycles without mem_ready before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request, held until ack0
- we0  in  1  port 0 write enable
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- rdata0  out  DATA_W  port 0 read data, registered
- ack0  out  1  port 0 completion pulse
- req1, we1, addr1, wdata1, rdata1, ack1  as port 0, for port 1
- err  out  1  pulses with ack when the transaction timed out
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion
- gnt  out  1  port currently granted (0/1), registered

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; ack0=ack1=err=0; rdata0=rdata1=0; gnt=0; last_gnt=1; timeout counter=0.
  - mem_req=mem_we=0 while reset is asserted.
  - Reset mid-transaction abandons it: no ack is issued and memory sees mem_req drop.
- IDLE:
  - mem_req=0.
  - If req0|req1 at the clock edge: load gnt, clear counter, go to BUSY.
  - Arbitration: req0 alone -> gnt=0; req1 alone -> gnt=1; both -> gnt=0 (fixed priority, see Optional Feature).
- BUSY:
  - mem_req=1; mem_we/mem_addr/mem_wdata combinationally muxed from the granted port.
  - mem_we is forced to 0 whenever mem_req=0.
  - Requester must hold its inputs stable until its ack.
  - If mem_ready=1: latch mem_rdata into rdata[gnt] (writes also latch; the value is don't-care), go to DONE with ack[gnt]=1.
  - Else if counter==TIMEOUT_CYCLES-1: go to DONE with ack[gnt]=1, err=1, rdata[gnt]=0.
  - Else counter += 1 (saturating 8-bit).
  - mem_ready outside BUSY is ignored.
- DONE:
  - mem_req=0; ack and err asserted for exactly this one cycle.
  - Requests are ignored in DONE, so a requester still holding req is not re-granted.
  - last_gnt<=gnt; go to IDLE.
- Latency:
  - req seen in IDLE at edge t -> mem_req high cycle t+1.
  - mem_ready at cycle t+k (k>=1) -> ack during cycle t+k+1; IDLE at t+k+2.
  - Minimum 3 cycles per transaction; back-to-back transactions issue every 3 cycles.
- Ungranted port: ack stays 0 and rdata holds its last value.
- Only ack[gnt] may pulse; ack0 and ack1 are never high together.
- err is only ever high together with an ack.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant goes to !last_gnt. After reset last_gnt=1, so the first contended grant goes to port 0.
- Undefined: fixed priority, port 0 always wins contention; last_gnt is unused.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Read, zero wait: reset; req0=1, we0=0, addr0=0x100; memory returns mem_rdata=0xDEADBEEF with mem_ready in the first BUSY cycle -> mem_req high 1 cycle, ack0 pulse on the next cycle, rdata0=0xDEADBEEF, err=0, total 3 cycles.
- Write with wait states: req1=1, we1=1, addr1=0x40, wdata1=0x12345678; mem_ready after 4 BUSY cycles -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 for 4 cycles; ack1 one pulse; ack0 stays 0.
- Contention: req0=req1=1 held, each dropped after its ack.
  - Fixed-priority build: grant order 0,1.
  - ARB_ROUND_ROBIN_EN build, both held for 4 transactions: grants 0,1,0,1.
- Timeout: TIMEOUT_CYCLES=4; req0 with mem_ready tied 0 -> mem_req high exactly 4 cycles, then ack0=1, err=1, rdata0=0; then IDLE.
- Reset mid-op: assert reset during BUSY cycle 2 -> mem_req=0 immediately; no ack; gnt=0; after release, a fresh req0 completes normally.
- Held req after ack: keep req0=1 through DONE -> no grant in the DONE cycle; second transaction begins exactly 3 cycles after the first.
